ber_phase_sweep_ctrl: RTL and testbench

//   Sequences the BER checker across all downsampling phases and picks the best one.
//   Per phase: reset checker, let it sync, count MEAS_SAMPLES, capture error count.

---
 rtl/ber_pkg.sv | 20 ++
 rtl/ber_valid_cnt.sv | 28 ++
 rtl/ber_phase_sweep_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ber_phase_sweep_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_pkg.sv
// Shared definitions for the BER phase-sweep controller.
// Holds the sweep FSM state encoding, the default checker counter width,
// and a helper that sizes phase-index buses.
package ber_pkg;

  localparam int NB_BER_CNT_DEF = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_SYNC  = 3'd2;
  localparam logic [2:0] ST_MEAS  = 3'd3;
  localparam logic [2:0] ST_CAPT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Width of a bus that indexes n phases; never narrower than one bit.
  function automatic int phase_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ber_valid_cnt.sv
// Saturating event counter with a run-time terminal value.
// hit pulses on the increment that brings the count to the terminal; the
// count never climbs past the terminal. The owner clears it via clr.
module ber_valid_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] terminal,
  output logic         hit
);

  logic [W-1:0] count;

  assign hit = inc && (count == (terminal - 1'b1));

  // Count qualified events, holding at the terminal value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != terminal)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ber_phase_sweep_ctrl.sv
// BER phase-sweep controller.
// Walks the BER checker through every downsampling phase: reset it, let it
// sync for SYNC_VALIDS valid samples, measure MEAS_SAMPLES more, capture the
// error count, and finally publish the lowest-error phase (lowest index wins
// ties). Optional valid-starvation watchdog is built when BER_TIMEOUT_EN is
// defined; otherwise o_timeout is tied low and the sweep waits forever.
//
// Handshake: i_start is a single-cycle request accepted only in IDLE and
// only when i_stop is low; i_stop aborts any active sweep on the next edge.
// o_done is a one-cycle completion strobe and is never raised by an abort.
module ber_phase_sweep_ctrl
  import ber_pkg::*;
#(
  parameter int N_PHASES     = 4,
  parameter int NB_BER_CNT   = NB_BER_CNT_DEF,
  parameter int SYNC_VALIDS  = 261121,
  parameter int MEAS_SAMPLES = 1024,
  parameter int TIMEOUT      = 4096
) (
  input  logic                          clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_stop,
  input  logic                          i_valid,
  input  logic [NB_BER_CNT-1:0]         i_ber_error,
  input  logic                          i_ber_zero,
  output logic                          o_ber_rst,
  output logic                          o_ber_en,
  output logic [phase_w(N_PHASES)-1:0]  o_phase_sel,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [phase_w(N_PHASES)-1:0]  o_best_phase,
  output logic [NB_BER_CNT-1:0]         o_best_err,
  output logic                          o_best_zero,
  output logic                          o_timeout,
  output logic [2:0]                    state_dbg
);

  localparam int PW = phase_w(N_PHASES);

  // One counter width covers the sync, measure and watchdog terminals.
  localparam int CNT_MAX_A = (SYNC_VALIDS > MEAS_SAMPLES) ? SYNC_VALIDS : MEAS_SAMPLES;
  localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT) ? CNT_MAX_A : TIMEOUT;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SYNC_TERM  = CW'(SYNC_VALIDS);
  localparam logic [CW-1:0] MEAS_TERM  = CW'(MEAS_SAMPLES);
  localparam logic [PW-1:0] LAST_PHASE = PW'(N_PHASES - 1);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic                  start_acc;
  logic                  in_win;
  logic                  last_phase;
  logic [CW-1:0]         v_term;
  logic                  v_hit;
  logic                  tmo_hit;

  logic [PW-1:0]         phase_idx;
  logic [PW-1:0]         run_phase;
  logic [NB_BER_CNT-1:0] run_err;
  logic                  run_zero;
  logic [PW-1:0]         sel_hold;
  logic [PW-1:0]         best_phase;
  logic [NB_BER_CNT-1:0] best_err;
  logic                  best_zero;

  assign start_acc  = i_start && !i_stop;
  assign in_win     = (state == ST_SYNC) || (state == ST_MEAS);
  assign last_phase = (phase_idx == LAST_PHASE);
  assign v_term     = (state == ST_SYNC) ? SYNC_TERM : MEAS_TERM;
  assign state_dbg  = state;

  // Valid-sample counter shared by the sync and measure windows.
  ber_valid_cnt #(.W(CW)) u_valid_cnt (
    .clk      (clk),
    .rst      (i_rst),
    .clr      (!in_win || v_hit),
    .inc      (in_win && i_valid),
    .terminal (v_term),
    .hit      (v_hit)
  );

`ifdef BER_TIMEOUT_EN
  logic timeout_q;

  // Watchdog: consecutive cycles in a sample window with no i_valid.
  ber_valid_cnt #(.W(CW)) u_tmo_cnt (
    .clk      (clk),
    .rst      (i_rst),
    .clr      (!in_win || i_valid || tmo_hit),
    .inc      (in_win && !i_valid),
    .terminal (CW'(TIMEOUT)),
    .hit      (tmo_hit)
  );

  // Sticky abort flag, cleared when the next sweep is accepted.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      timeout_q <= 1'b0;
    end else if ((state == ST_IDLE) && start_acc) begin
      timeout_q <= 1'b0;
    end else if (tmo_hit && !i_stop) begin
      timeout_q <= 1'b1;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign tmo_hit   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort paths take priority over normal progress.
  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE) begin
      if (start_acc) state_nxt = ST_CLEAR;
    end else if (i_stop || tmo_hit) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_CLEAR: state_nxt = ST_SYNC;
        ST_SYNC:  if (v_hit) state_nxt = ST_MEAS;
        ST_MEAS:  if (v_hit) state_nxt = ST_CAPT;
        ST_CAPT:  state_nxt = last_phase ? ST_DONE : ST_CLEAR;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Checker control and status outputs decoded from the current state.
  always_comb begin
    o_ber_rst   = 1'b0;
    o_ber_en    = 1'b0;
    o_done      = 1'b0;
    o_busy      = (state != ST_IDLE);
    o_phase_sel = sel_hold;
    case (state)
      ST_CLEAR: begin
        o_ber_rst   = 1'b1;
        o_phase_sel = phase_idx;
      end
      ST_SYNC, ST_MEAS: begin
        o_ber_en    = 1'b1;
        o_phase_sel = phase_idx;
      end
      ST_CAPT:  o_phase_sel = phase_idx;
      ST_DONE:  o_done      = 1'b1;
      default:  o_phase_sel = sel_hold;
    endcase
  end

  // Phase stepping, running minimum and published results.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      phase_idx  <= '0;
      run_phase  <= '0;
      run_err    <= '1;
      run_zero   <= 1'b0;
      sel_hold   <= '0;
      best_phase <= '0;
      best_err   <= '1;
      best_zero  <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start_acc) begin
        phase_idx <= '0;
        run_phase <= '0;
        run_err   <= '1;
        run_zero  <= 1'b0;
      end
      if (state == ST_CAPT) begin
        // Strict compare keeps the earlier (lower) phase on a tie.
        if (i_ber_error < run_err) begin
          run_err   <= i_ber_error;
          run_phase <= phase_idx;
          run_zero  <= i_ber_zero;
        end
        if (!last_phase) phase_idx <= phase_idx + 1'b1;
      end
      if (state == ST_DONE) begin
        best_phase <= run_phase;
        best_err   <= run_err;
        best_zero  <= run_zero;
        sel_hold   <= run_phase;
      end
    end
  end

  assign o_best_phase = best_phase;
  assign o_best_err   = best_err;
  assign o_best_zero  = best_zero;

endmodule

// File: tb/tb_ber_phase_sweep_ctrl.sv
// Bench for ber_phase_sweep_ctrl with a small sweep configuration and a
// behavioural checker stub that reports a per-phase error count.
module tb_ber_phase_sweep_ctrl;
  import ber_pkg::*;

  localparam int NP   = 4;
  localparam int SV   = 8;
  localparam int MS   = 16;
  localparam int TO   = 32;
  localparam int VMAX = 4096;
  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [3:0][7:0] errs;
    int              period;
    int              exp_phase;
    int              exp_err;
    bit              exp_zero;
    int              exp_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        valid = 1'b0;
  logic [63:0] ber_error;
  logic        ber_zero;
  logic        ber_rst, ber_en, busy, done, best_zero, timeout;
  logic [1:0]  phase_sel, best_phase;
  logic [63:0] best_err;
  logic [2:0]  state_dbg;

  logic [3:0][7:0] cur_err;
  bit              vseq [VMAX];
  int              vec_cnt = 0;
  int              err_cnt = 0;
  vec_t            tab [4];

  ber_phase_sweep_ctrl #(
    .N_PHASES(NP), .NB_BER_CNT(64), .SYNC_VALIDS(SV),
    .MEAS_SAMPLES(MS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_valid(valid),
    .i_ber_error(ber_error), .i_ber_zero(ber_zero),
    .o_ber_rst(ber_rst), .o_ber_en(ber_en), .o_phase_sel(phase_sel),
    .o_busy(busy), .o_done(done), .o_best_phase(best_phase),
    .o_best_err(best_err), .o_best_zero(best_zero), .o_timeout(timeout),
    .state_dbg(state_dbg)
  );

  // Checker stub: error count of whichever phase is currently selected.
  assign ber_error = {56'd0, cur_err[phase_sel]};
  assign ber_zero  = (ber_error == 64'd0);

  // Clock and hard time limit.
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit act=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0][7:0] mk_errs(input int a, input int b, input int c, input int d);
    logic [3:0][7:0] e;
    e[0] = 8'(a); e[1] = 8'(b); e[2] = 8'(c); e[3] = 8'(d);
    return e;
  endfunction

  task automatic fill_periodic(input int p);
    for (int k = 0; k < VMAX; k++) vseq[k] = ((k % p) == 0);
  endtask

  // Reference: busy cycles = per phase 1 clear + cycles to gather SV+MS
  // valids + 1 capture, then 1 done cycle. Cycle 1 is the first busy cycle.
  function automatic int model_busy();
    int t = 1;
    for (int ph = 0; ph < NP; ph++) begin
      int n = 0;
      t++;
      while (n < SV + MS && t < VMAX - 1) begin
        if (vseq[t]) n++;
        t++;
      end
      t++;
    end
    t++;
    return t - 1;
  endfunction

  // Reference: first phase holding the minimum error.
  task automatic model_best(output int ph, output int err);
    err = 256;
    ph  = 0;
    for (int i = 0; i < NP; i++) begin
      if (int'(cur_err[i]) < err) begin
        err = int'(cur_err[i]);
        ph  = i;
      end
    end
  endtask

  // Driver: start at k=0, drive vseq as i_valid, optionally re-pulse start,
  // run until busy drops, counting busy cycles and done pulses.
  task automatic run_sweep(input int restart_k, output int busy_n, output int done_n);
    bit ok = 1'b0;
    busy_n = 0;
    done_n = 0;
    for (int k = 0; k < VMAX - 1; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (busy) busy_n++;
        if (done) done_n++;
        if (!busy) begin
          ok = 1'b1;
          break;
        end
      end
      start = (k == 0) || (k == restart_k);
      valid = vseq[k];
    end
    start = 1'b0;
    valid = 1'b0;
    chk("sweep_finished", 64'(ok), 64'd1);
  endtask

  task automatic check_result(input string tag, input int bn, input int dn, input int e_busy,
                              input int e_ph, input int e_err, input bit e_zero);
    chk({tag, "_done_cnt"}, 64'(dn), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(bn), 64'(e_busy));
    chk({tag, "_best_phase"}, 64'(best_phase), 64'(e_ph));
    chk({tag, "_best_err"}, best_err, 64'(e_err));
    chk({tag, "_best_zero"}, 64'(best_zero), 64'(e_zero));
    chk({tag, "_phase_sel"}, 64'(phase_sel), 64'(e_ph));
    chk({tag, "_ber_en_idle"}, 64'(ber_en), 64'd0);
  endtask

  initial begin
    int bn, dn, eph, eerr, dsum;

    tab[0] = '{mk_errs(5, 2, 9, 2), 1, 1, 2, 1'b0, 105};
    tab[1] = '{mk_errs(0, 3, 3, 3), 1, 0, 0, 1'b1, 105};
    tab[2] = '{mk_errs(7, 7, 7, 7), 3, 0, 7, 1'b0, 290};
    tab[3] = '{mk_errs(9, 8, 7, 6), 2, 3, 6, 1'b0, 200};
    cur_err = mk_errs(0, 0, 0, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ber_en", 64'(ber_en), 64'd0);
    chk("rst_ber_rst", 64'(ber_rst), 64'd0);
    chk("rst_phase_sel", 64'(phase_sel), 64'd0);
    chk("rst_best_phase", 64'(best_phase), 64'd0);
    chk("rst_best_err", best_err, ALL_ONES);
    chk("rst_best_zero", 64'(best_zero), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);

    // Table-driven full sweeps.
    for (int i = 0; i < 4; i++) begin
      cur_err = tab[i].errs;
      fill_periodic(tab[i].period);
      run_sweep(-1, bn, dn);
      check_result($sformatf("row%0d", i), bn, dn, tab[i].exp_busy,
                   tab[i].exp_phase, tab[i].exp_err, tab[i].exp_zero);
    end

    // Second start while busy is ignored.
    cur_err = mk_errs(4, 1, 1, 3);
    fill_periodic(1);
    run_sweep(30, bn, dn);
    check_result("restart", bn, dn, 105, 1, 1, 1'b0);

    // Abort during phase 2 measurement keeps the previous results.
    cur_err = mk_errs(0, 0, 0, 0);
    dsum = 0;
    for (int k = 0; k <= 65; k++) begin
      @(negedge clk);
      if (k > 0 && done) dsum++;
      start = (k == 0);
      valid = 1'b1;
    end
    chk("stop_pre_ber_en", 64'(ber_en), 64'd1);
    chk("stop_pre_phase", 64'(phase_sel), 64'd2);
    chk("stop_pre_state", 64'(state_dbg), 64'(ST_MEAS));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    valid = 1'b0;
    if (done) dsum++;
    chk("stop_busy", 64'(busy), 64'd0);
    chk("stop_ber_en", 64'(ber_en), 64'd0);
    chk("stop_no_done", 64'(dsum), 64'd0);
    chk("stop_best_phase", 64'(best_phase), 64'd1);
    chk("stop_best_err", best_err, 64'd1);

    // Stop and start together in IDLE: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("stop_start_idle", 64'(busy), 64'd0);

    // Randomised sweeps against the reference model.
    for (int r = 0; r < 8; r++) begin
      int eb;
      cur_err = mk_errs($urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, 7));
      for (int k = 0; k < VMAX; k++) vseq[k] = ($urandom_range(0, 3) != 0);
      model_best(eph, eerr);
      eb = model_busy();
      run_sweep(-1, bn, dn);
      check_result($sformatf("rand%0d", r), bn, dn, eb, eph, eerr, (eerr == 0));
    end

    // Reset in the middle of SYNC clears published results.
    fill_periodic(1);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      start = (k == 0);
      valid = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ber_en", 64'(ber_en), 64'd0);
    chk("midrst_best_err", best_err, ALL_ONES);
    chk("midrst_best_phase", 64'(best_phase), 64'd0);
    chk("midrst_phase_sel", 64'(phase_sel), 64'd0);

    // Valid starvation in SYNC: watchdog aborts on the 32nd idle cycle
    // when built in, otherwise the sweep keeps waiting.
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      if (k == 33) chk("starve_busy_33", 64'(busy), 64'd1);
      if (k == 34) begin
`ifdef BER_TIMEOUT_EN
        chk("starve_busy_34", 64'(busy), 64'd0);
        chk("starve_timeout", 64'(timeout), 64'd1);
        chk("starve_no_done", 64'(done), 64'd0);
`else
        chk("starve_busy_34", 64'(busy), 64'd1);
        chk("starve_timeout", 64'(timeout), 64'd0);
        chk("starve_ber_en", 64'(ber_en), 64'd1);
`endif
      end
      start = (k == 0);
      valid = 1'b0;
    end
    start = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    chk("final_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
